// File: rtl/object_slot_scheduler.sv
// Collider object-slot pool allocator.
// Arbitrates attack/platform spawn requests (round-robin on ties), hands out
// the lowest free slot, and runs a per-slot destroy countdown on the
// centisecond tick. object_ready_state is the registered free vector.
module object_slot_scheduler #(
  parameter int OBJECT_AMOUNT = 30,
  parameter int IDX_W         = 5,
  parameter int TIME_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_centi_second,
  input  logic                     clear_all,
  input  logic                     attack_req,
  input  logic [TIME_W-1:0]        attack_destroy_time,
  output logic                     attack_ack,
  input  logic                     platform_req,
  input  logic [TIME_W-1:0]        platform_destroy_time,
  output logic                     platform_ack,
  output logic                     alloc_valid,
  output logic [IDX_W-1:0]         alloc_idx,
  output logic                     alloc_src,
  output logic [OBJECT_AMOUNT-1:0] object_ready_state,
  output logic [OBJECT_AMOUNT-1:0] slot_release,
  output logic                     pool_full
);

  // free_q bit set = slot free; it is the registered ready vector itself
  logic [OBJECT_AMOUNT-1:0] free_q, free_d;
  logic [OBJECT_AMOUNT-1:0] release_q, release_d;
  logic [TIME_W-1:0]        cnt_q [OBJECT_AMOUNT];
  logic [TIME_W-1:0]        cnt_d [OBJECT_AMOUNT];
  logic                     att_ack_q, plt_ack_q;
  logic                     alloc_valid_q;
  logic [IDX_W-1:0]         alloc_idx_q, alloc_idx_d;
  logic                     alloc_src_q, alloc_src_d;
  logic                     pool_full_q, pool_full_d;
  // 1 = platform won the last grant, so attack wins the next tie
  logic                     last_grant_q, last_grant_d;

  logic                     free_any;
  logic [IDX_W-1:0]         first_idx;
  logic                     att_elig, plt_elig;
  logic                     grant_att, grant_plt, grant_any;
  logic [TIME_W-1:0]        grant_time;

  // Lowest-index free slot from the vector registered at the start of the cycle
  always_comb begin
    first_idx = '0;
    for (int i = OBJECT_AMOUNT - 1; i >= 0; i--) begin
      if (free_q[i]) first_idx = IDX_W'(i);
    end
  end

  // Eligibility and round-robin arbitration; an ack-high cycle masks the requester
  always_comb begin
    free_any   = |free_q;
    att_elig   = attack_req   & ~att_ack_q & ~clear_all & free_any;
    plt_elig   = platform_req & ~plt_ack_q & ~clear_all & free_any;
    grant_att  = att_elig & (~plt_elig |  last_grant_q);
    grant_plt  = plt_elig & (~att_elig | ~last_grant_q);
    grant_any  = grant_att | grant_plt;
    grant_time = grant_att ? attack_destroy_time : platform_destroy_time;
  end

  // Next-state for slots, countdowns and allocation outputs; clear_all dominates
  always_comb begin
    free_d       = free_q;
    release_d    = '0;
    alloc_idx_d  = alloc_idx_q;
    alloc_src_d  = alloc_src_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < OBJECT_AMOUNT; i++) cnt_d[i] = cnt_q[i];

    if (clear_all) begin
      free_d = '1;
      for (int i = 0; i < OBJECT_AMOUNT; i++) cnt_d[i] = '0;
    end else begin
      for (int i = 0; i < OBJECT_AMOUNT; i++) begin
        // A zero count on a busy slot marks it persistent
        if (clk_centi_second && !free_q[i] && cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - TIME_W'(1);
          if (cnt_q[i] == TIME_W'(1)) begin
            free_d[i]    = 1'b1;
            release_d[i] = 1'b1;
          end
        end
        // The granted slot is free, so it never collides with a decrement
        if (grant_any && (IDX_W'(i) == first_idx)) begin
          free_d[i] = 1'b0;
          cnt_d[i]  = grant_time;
        end
      end
      if (grant_any) begin
        alloc_idx_d  = first_idx;
        alloc_src_d  = grant_plt;
        last_grant_d = grant_plt;
      end
    end
    pool_full_d = ~|free_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q        <= '1;
      release_q     <= '0;
      att_ack_q     <= 1'b0;
      plt_ack_q     <= 1'b0;
      alloc_valid_q <= 1'b0;
      alloc_idx_q   <= '0;
      alloc_src_q   <= 1'b0;
      pool_full_q   <= 1'b0;
      last_grant_q  <= 1'b1;
      for (int i = 0; i < OBJECT_AMOUNT; i++) cnt_q[i] <= '0;
    end else begin
      free_q        <= free_d;
      release_q     <= release_d;
      att_ack_q     <= grant_att;
      plt_ack_q     <= grant_plt;
      alloc_valid_q <= grant_any;
      alloc_idx_q   <= alloc_idx_d;
      alloc_src_q   <= alloc_src_d;
      pool_full_q   <= pool_full_d;
      last_grant_q  <= last_grant_d;
      for (int i = 0; i < OBJECT_AMOUNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign attack_ack         = att_ack_q;
  assign platform_ack       = plt_ack_q;
  assign alloc_valid        = alloc_valid_q;
  assign alloc_idx          = alloc_idx_q;
  assign alloc_src          = alloc_src_q;
  assign object_ready_state = free_q;
  assign slot_release       = release_q;
  assign pool_full          = pool_full_q;

endmodule

// File: tb/tb_object_slot_scheduler.sv
// Directed bench for object_slot_scheduler.
module tb_object_slot_scheduler;

  localparam int N  = 30;
  localparam int IW = 5;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_centi_second;
  logic          clear_all;
  logic          attack_req;
  logic [TW-1:0] attack_destroy_time;
  logic          attack_ack;
  logic          platform_req;
  logic [TW-1:0] platform_destroy_time;
  logic          platform_ack;
  logic          alloc_valid;
  logic [IW-1:0] alloc_idx;
  logic          alloc_src;
  logic [N-1:0]  object_ready_state;
  logic [N-1:0]  slot_release;
  logic          pool_full;

  int total = 0;
  int bad   = 0;

  object_slot_scheduler #(.OBJECT_AMOUNT(N), .IDX_W(IW), .TIME_W(TW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .clk_centi_second      (clk_centi_second),
    .clear_all             (clear_all),
    .attack_req            (attack_req),
    .attack_destroy_time   (attack_destroy_time),
    .attack_ack            (attack_ack),
    .platform_req          (platform_req),
    .platform_destroy_time (platform_destroy_time),
    .platform_ack          (platform_ack),
    .alloc_valid           (alloc_valid),
    .alloc_idx             (alloc_idx),
    .alloc_src             (alloc_src),
    .object_ready_state    (object_ready_state),
    .slot_release          (slot_release),
    .pool_full             (pool_full)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_centi_second = 1'b0; clear_all = 1'b0;
    attack_req = 1'b0; platform_req = 1'b0;
    attack_destroy_time = '0; platform_destroy_time = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (object_ready_state !== {N{1'b1}}) begin bad++; $display("FAIL reset_ready got=%h exp=%h", object_ready_state, {N{1'b1}}); end
    total++; if ({attack_ack, platform_ack, alloc_valid} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", {attack_ack, platform_ack, alloc_valid}); end
    total++; if (pool_full !== 1'b0) begin bad++; $display("FAIL reset_pool_full got=%b exp=0", pool_full); end
    total++; if (slot_release !== '0) begin bad++; $display("FAIL reset_release got=%h exp=0", slot_release); end
  endtask

  task automatic test_single_attack();
    do_reset();
    attack_req = 1'b1; attack_destroy_time = 8'd3;
    step();
    total++; if ({attack_ack, alloc_valid, alloc_src} !== 3'b110) begin bad++; $display("FAIL single_ack got=%b exp=110", {attack_ack, alloc_valid, alloc_src}); end
    total++; if (alloc_idx !== 5'd0) begin bad++; $display("FAIL single_idx got=%0d exp=0", alloc_idx); end
    total++; if (object_ready_state[0] !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", object_ready_state[0]); end
    attack_req = 1'b0;
    step();
    total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse got=%b exp=0", alloc_valid); end
    for (int k = 1; k <= 3; k++) begin
      clk_centi_second = 1'b1;
      step();
      clk_centi_second = 1'b0;
      if (k < 3) begin
        total++; if ({slot_release[0], object_ready_state[0]} !== 2'b00) begin bad++; $display("FAIL single_tick%0d got=%b exp=00", k, {slot_release[0], object_ready_state[0]}); end
      end else begin
        total++; if ({slot_release[0], object_ready_state[0]} !== 2'b11) begin bad++; $display("FAIL single_expire got=%b exp=11", {slot_release[0], object_ready_state[0]}); end
      end
    end
    step();
    total++; if (slot_release !== '0) begin bad++; $display("FAIL single_release_pulse got=%h exp=0", slot_release); end
  endtask

  task automatic test_round_robin();
    do_reset();
    attack_req = 1'b1; platform_req = 1'b1;
    attack_destroy_time = 8'd0; platform_destroy_time = 8'd0;
    step();
    total++; if ({attack_ack, platform_ack, alloc_src, alloc_idx} !== {3'b100, 5'd0}) begin bad++; $display("FAIL rr_tie1 got=%b/%0d exp=100/0", {attack_ack, platform_ack, alloc_src}, alloc_idx); end
    attack_req = 1'b0;
    step();
    total++; if ({attack_ack, platform_ack, alloc_src, alloc_idx} !== {3'b011, 5'd1}) begin bad++; $display("FAIL rr_plat1 got=%b/%0d exp=011/1", {attack_ack, platform_ack, alloc_src}, alloc_idx); end
    platform_req = 1'b0;
    attack_req = 1'b1;
    step();
    total++; if ({attack_ack, alloc_idx} !== {1'b1, 5'd2}) begin bad++; $display("FAIL rr_solo got=%b/%0d exp=1/2", attack_ack, alloc_idx); end
    attack_req = 1'b0;
    step();
    attack_req = 1'b1; platform_req = 1'b1;
    step();
    total++; if ({attack_ack, platform_ack, alloc_src, alloc_idx} !== {3'b011, 5'd3}) begin bad++; $display("FAIL rr_tie2 got=%b/%0d exp=011/3", {attack_ack, platform_ack, alloc_src}, alloc_idx); end
    platform_req = 1'b0;
    step();
    total++; if ({attack_ack, platform_ack, alloc_idx} !== {2'b10, 5'd4}) begin bad++; $display("FAIL rr_after got=%b/%0d exp=10/4", {attack_ack, platform_ack}, alloc_idx); end
    attack_req = 1'b0;
    step();
  endtask

  task automatic test_fill_and_clear();
    int miss;
    do_reset();
    miss = 0;
    attack_req = 1'b1; attack_destroy_time = 8'd0;
    for (int i = 0; i < N; i++) begin
      step();
      if (attack_ack !== 1'b1 || alloc_idx !== IW'(i)) miss++;
      step();
      if (attack_ack !== 1'b0) miss++;
    end
    total++; if (miss != 0) begin bad++; $display("FAIL fill_sequence got=%0d misses exp=0", miss); end
    total++; if ({pool_full, object_ready_state} !== {1'b1, {N{1'b0}}}) begin bad++; $display("FAIL fill_full got=%b/%h exp=1/0", pool_full, object_ready_state); end
    miss = 0;
    repeat (3) begin
      step();
      if (attack_ack !== 1'b0 || alloc_valid !== 1'b0) miss++;
    end
    total++; if (miss != 0) begin bad++; $display("FAIL full_stall got=%0d acks exp=0", miss); end
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    total++; if ({pool_full, attack_ack, object_ready_state} !== {2'b00, {N{1'b1}}}) begin bad++; $display("FAIL clear_state got=%b/%h exp=00/all-ones", {pool_full, attack_ack}, object_ready_state); end
    total++; if (slot_release !== '0) begin bad++; $display("FAIL clear_release got=%h exp=0", slot_release); end
    step();
    total++; if ({attack_ack, alloc_idx} !== {1'b1, 5'd0}) begin bad++; $display("FAIL clear_regrant got=%b/%0d exp=1/0", attack_ack, alloc_idx); end
    attack_req = 1'b0;
    step();
  endtask

  task automatic test_tick_on_alloc();
    do_reset();
    attack_req = 1'b1; attack_destroy_time = 8'd1; clk_centi_second = 1'b1;
    step();
    attack_req = 1'b0; clk_centi_second = 1'b0;
    total++; if ({attack_ack, object_ready_state[0], slot_release[0]} !== 3'b100) begin bad++; $display("FAIL tickalloc_load got=%b exp=100", {attack_ack, object_ready_state[0], slot_release[0]}); end
    step();
    total++; if (object_ready_state[0] !== 1'b0) begin bad++; $display("FAIL tickalloc_hold got=%b exp=0", object_ready_state[0]); end
    clk_centi_second = 1'b1;
    step();
    clk_centi_second = 1'b0;
    total++; if ({slot_release[0], object_ready_state[0]} !== 2'b11) begin bad++; $display("FAIL tickalloc_expire got=%b exp=11", {slot_release[0], object_ready_state[0]}); end
  endtask

  task automatic test_release_collision();
    do_reset();
    attack_req = 1'b1; attack_destroy_time = 8'd1;
    step();
    attack_req = 1'b0;
    step();
    attack_req = 1'b1; attack_destroy_time = 8'd0; clk_centi_second = 1'b1;
    step();
    clk_centi_second = 1'b0;
    total++; if ({attack_ack, alloc_idx} !== {1'b1, 5'd1}) begin bad++; $display("FAIL collide_idx got=%b/%0d exp=1/1", attack_ack, alloc_idx); end
    total++; if ({slot_release[0], object_ready_state[1:0]} !== 3'b101) begin bad++; $display("FAIL collide_state got=%b exp=101", {slot_release[0], object_ready_state[1:0]}); end
    step();
    total++; if (attack_ack !== 1'b0) begin bad++; $display("FAIL collide_gap got=%b exp=0", attack_ack); end
    step();
    total++; if ({attack_ack, alloc_idx} !== {1'b1, 5'd0}) begin bad++; $display("FAIL collide_reuse got=%b/%0d exp=1/0", attack_ack, alloc_idx); end
    attack_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_attack();
    test_round_robin();
    test_fill_and_clear();
    test_tick_on_alloc();
    test_release_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
